// File: rtl/dff_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: request/data in, grant/ack/status out.
// The master modport faces the producers and the slave modport faces the arbiter.
interface dff_reg_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int OWNER_W = 2
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] din;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       q;
  logic                   q_valid;
  logic                   busy;
  logic [OWNER_W-1:0]     owner;

  modport master (
    output req, din,
    input  gnt, ack, q, q_valid, busy, owner
  );

  modport slave (
    input  req, din,
    output gnt, ack, q, q_valid, busy, owner
  );
endinterface

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter that loads one requester's word into a shared register,
// holds the grant for HOLD_CYCLES cycles, then rotates priority past the owner.
module dff_reg_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int OWNER_W     = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  dff_reg_arbiter_if.slave bus
);

  localparam int                   CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [OWNER_W:0]     N_REQ_X   = (OWNER_W + 1)'(N_REQ);
  localparam logic [OWNER_W-1:0]   OWNER_MAX = OWNER_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0]     ONE_HOT0  = N_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_HOLD
  } state_t;

  state_t             state_reg;
  logic [OWNER_W-1:0] ptr_reg;
  logic [OWNER_W-1:0] owner_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [N_REQ-1:0]   gnt_reg;
  logic [N_REQ-1:0]   ack_reg;
  logic [WIDTH-1:0]   q_reg;
  logic               q_valid_reg;
  logic               busy_reg;

  logic [WIDTH-1:0]   din_arr [N_REQ];
  logic [OWNER_W-1:0] win_next;
  logic [OWNER_W:0]   cand;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_din
      assign din_arr[gi] = bus.din[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Scan from the farthest offset back towards ptr so the nearest set bit wins.
  always_comb begin
    win_next = '0;
    cand     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_reg} + (OWNER_W + 1)'(k);
      if (cand >= N_REQ_X) begin
        cand = cand - N_REQ_X;
      end
      if (bus.req[cand[OWNER_W-1:0]]) begin
        win_next = cand[OWNER_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      ptr_reg     <= '0;
      owner_reg   <= '0;
      cnt_reg     <= '0;
      gnt_reg     <= '0;
      ack_reg     <= '0;
      q_reg       <= '0;
      q_valid_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (|bus.req) begin
            state_reg <= S_GRANT;
            gnt_reg   <= ONE_HOT0 << win_next;
            owner_reg <= win_next;
            busy_reg  <= 1'b1;
          end
        end
        S_GRANT: begin
          // gnt_reg is already one-hot on the owner, so it doubles as the ack pattern.
          q_reg       <= din_arr[owner_reg];
          q_valid_reg <= 1'b1;
          ack_reg     <= gnt_reg;
          cnt_reg     <= '0;
          state_reg   <= S_HOLD;
        end
        S_HOLD: begin
          ack_reg <= '0;
          if (cnt_reg == CNT_LAST) begin
            gnt_reg   <= '0;
            busy_reg  <= 1'b0;
            ptr_reg   <= (owner_reg == OWNER_MAX) ? '0 : owner_reg + OWNER_W'(1);
            state_reg <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_reg;
  assign bus.ack     = ack_reg;
  assign bus.q       = q_reg;
  assign bus.q_valid = q_valid_reg;
  assign bus.busy    = busy_reg;
  assign bus.owner   = owner_reg;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Bench for dff_reg_arbiter: directed scenarios plus random traffic, checked against a
// transaction-level model (rotating pointer, per-transaction timeline of grant/ack/load).
module tb_dff_reg_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dff_reg_arbiter_if #(.N_REQ(N), .WIDTH(W), .OWNER_W(2)) bus ();

  dff_reg_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_CYCLES(H), .OWNER_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: rotation pointer and last-known register/owner contents.
  int         m_ptr;
  logic [7:0] m_q;
  logic       m_qv;
  int         m_owner;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_winner(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Observed status packed as {gnt, ack, busy, q_valid, owner, q}.
  function automatic logic [19:0] obs();
    return {bus.gnt, bus.ack, bus.busy, bus.q_valid, bus.owner, bus.q};
  endfunction

  // Expected status in cycle lc (1 = first grant cycle) of a transaction won by w.
  function automatic logic [19:0] txn_exp(input int lc, input int w, input logic [7:0] nq,
                                          input logic [7:0] oq, input logic oqv);
    logic [3:0] oh, g, a;
    logic       b, v;
    logic [7:0] qq;
    oh = 4'(1 << w);
    b  = (lc >= 1) && (lc <= 1 + H);
    g  = b ? oh : 4'b0;
    a  = (lc == 2) ? oh : 4'b0;
    v  = (lc >= 2) ? 1'b1 : oqv;
    qq = (lc >= 2) ? nq : oq;
    return {g, a, b, v, 2'(w), qq};
  endfunction

  function automatic logic [19:0] idle_exp();
    return {4'b0, 4'b0, 1'b0, m_qv, 2'(m_owner), m_q};
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_q = 8'h00; m_qv = 1'b0; m_owner = 0;
  endtask

  task automatic model_done(input int w, input logic [7:0] nq);
    m_ptr = (w + 1) % N; m_owner = w; m_q = nq; m_qv = 1'b1;
  endtask

  task automatic test_reset();
    int         w;
    logic [7:0] nq;
    bus.req = '0;
    bus.din = '0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (obs() !== 20'h0) begin
      n_fail++; $display("FAIL reset_async got=%h exp=%h", obs(), 20'h0);
    end
    step(); step();
    n_tests++;
    if (obs() !== 20'h0) begin
      n_fail++; $display("FAIL reset_held got=%h exp=%h", obs(), 20'h0);
    end
    rst_n = 1'b1;
    // Run a transaction, then pulse reset between edges once Q has loaded.
    bus.din = 32'($urandom);
    bus.din[15:8] = 8'h5A;
    bus.req = 4'b0010;
    w  = model_winner(bus.req, m_ptr);
    nq = bus.din[w*W +: W];
    for (int lc = 1; lc <= 2; lc++) begin
      step();
      n_tests++;
      if (obs() !== txn_exp(lc, w, nq, m_q, m_qv)) begin
        n_fail++; $display("FAIL reset_pre_txn lc=%0d got=%h exp=%h", lc, obs(), txn_exp(lc, w, nq, m_q, m_qv));
      end
    end
    #3 rst_n = 1'b0;
    bus.req = '0;
    #1;
    model_reset();
    n_tests++;
    if (obs() !== 20'h0) begin
      n_fail++; $display("FAIL reset_midrun got=%h exp=%h", obs(), 20'h0);
    end
    #2 rst_n = 1'b1;
    step();
    n_tests++;
    if (obs() !== idle_exp()) begin
      n_fail++; $display("FAIL reset_idle_after got=%h exp=%h", obs(), idle_exp());
    end
    $display("[TB] txn reset: req=0010 winner=%0d aborted by reset", w);
  endtask

  task automatic test_single();
    int         w;
    logic [7:0] oq, nq;
    logic       oqv;
    bus.din = 32'($urandom);
    bus.din[23:16] = 8'hA5;
    bus.req = 4'b0100;
    w = model_winner(bus.req, m_ptr);
    oq = m_q; oqv = m_qv; nq = 8'hA5;
    for (int lc = 1; lc <= 5; lc++) begin
      step();
      n_tests++;
      if (obs() !== txn_exp(lc, w, nq, oq, oqv)) begin
        n_fail++; $display("FAIL single lc=%0d got=%h exp=%h", lc, obs(), txn_exp(lc, w, nq, oq, oqv));
      end
      if (lc == 2) bus.req = '0;
    end
    model_done(w, nq);
    $display("[TB] txn single: req=0100 winner=%0d q=%h", w, nq);
  endtask

  task automatic test_back_to_back();
    int         w;
    int         order[$];
    logic [3:0] prev_gnt;
    logic [7:0] oq, nq;
    logic       oqv;
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
    bus.din = 32'($urandom);
    bus.req = 4'b1111;
    prev_gnt = 4'b0;
    for (int k = 0; k < 5; k++) begin
      w  = model_winner(bus.req, m_ptr);
      oq = m_q; oqv = m_qv;
      nq = bus.din[w*W +: W];
      for (int lc = 1; lc <= 2 + H; lc++) begin
        step();
        if (bus.gnt != 4'b0 && prev_gnt == 4'b0) order.push_back(int'(bus.owner));
        prev_gnt = bus.gnt;
        n_tests++;
        if (obs() !== txn_exp(lc, w, nq, oq, oqv)) begin
          n_fail++; $display("FAIL back_to_back k=%0d lc=%0d got=%h exp=%h", k, lc, obs(), txn_exp(lc, w, nq, oq, oqv));
        end
        if (k == 4 && lc == 2) bus.req = '0;
      end
      model_done(w, nq);
      $display("[TB] txn back_to_back %0d: req=1111 winner=%0d q=%h", k, w, nq);
    end
    n_tests++;
    if (order.size() != 5 || order[0] != 0 || order[1] != 1 || order[2] != 2 ||
        order[3] != 3 || order[4] != 0) begin
      n_fail++; $display("FAIL back_to_back_order got=%p exp=0,1,2,3,0", order);
    end
  endtask

  task automatic test_wrap();
    int         w;
    int         seen[3];
    logic [7:0] oq, nq;
    logic       oqv;
    bus.din = 32'($urandom);
    bus.req = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      w  = model_winner(bus.req, m_ptr);
      oq = m_q; oqv = m_qv;
      nq = bus.din[w*W +: W];
      for (int lc = 1; lc <= 2 + H; lc++) begin
        step();
        if (lc == 1) seen[k] = int'(bus.owner);
        n_tests++;
        if (obs() !== txn_exp(lc, w, nq, oq, oqv)) begin
          n_fail++; $display("FAIL wrap k=%0d lc=%0d got=%h exp=%h", k, lc, obs(), txn_exp(lc, w, nq, oq, oqv));
        end
        if (lc == 2) bus.req = (k == 2) ? 4'b0000 : 4'b1001;
      end
      model_done(w, nq);
      $display("[TB] txn wrap %0d: winner=%0d q=%h", k, w, nq);
    end
    n_tests++;
    if (seen[0] != 3 || seen[1] != 0 || seen[2] != 3) begin
      n_fail++; $display("FAIL wrap_order got=%0d,%0d,%0d exp=3,0,3", seen[0], seen[1], seen[2]);
    end
  endtask

  task automatic test_drop_req();
    int         w;
    logic [7:0] oq, nq;
    logic       oqv;
    bus.din = 32'($urandom);
    bus.din[15:8] = 8'h3C;
    bus.req = 4'b0010;
    w = model_winner(bus.req, m_ptr);
    oq = m_q; oqv = m_qv; nq = 8'h3C;
    for (int lc = 1; lc <= 5; lc++) begin
      step();
      n_tests++;
      if (obs() !== txn_exp(lc, w, nq, oq, oqv)) begin
        n_fail++; $display("FAIL drop_req lc=%0d got=%h exp=%h", lc, obs(), txn_exp(lc, w, nq, oq, oqv));
      end
      if (lc == 1) bus.req = '0;
      if (lc == 2) bus.din[15:8] = 8'hFF;
    end
    model_done(w, nq);
    $display("[TB] txn drop_req: req=0010 winner=%0d q=%h", w, nq);
  endtask

  task automatic test_reset_mid_hold();
    int         w;
    logic [7:0] oq, nq;
    logic       oqv;
    bus.din = 32'($urandom);
    bus.req = 4'b0110;
    w = model_winner(bus.req, m_ptr);
    oq = m_q; oqv = m_qv;
    nq = bus.din[w*W +: W];
    for (int lc = 1; lc <= 3; lc++) begin
      step();
      n_tests++;
      if (obs() !== txn_exp(lc, w, nq, oq, oqv)) begin
        n_fail++; $display("FAIL hold_abort_pre lc=%0d got=%h exp=%h", lc, obs(), txn_exp(lc, w, nq, oq, oqv));
      end
    end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (obs() !== 20'h0) begin
      n_fail++; $display("FAIL hold_abort_reset got=%h exp=%h", obs(), 20'h0);
    end
    #2 rst_n = 1'b1;
    $display("[TB] txn hold_abort: req=0110 winner=%0d aborted in hold", w);
    w  = model_winner(bus.req, m_ptr);
    oq = m_q; oqv = m_qv;
    nq = bus.din[w*W +: W];
    for (int lc = 1; lc <= 2 + H; lc++) begin
      step();
      n_tests++;
      if (obs() !== txn_exp(lc, w, nq, oq, oqv)) begin
        n_fail++; $display("FAIL hold_abort_restart lc=%0d got=%h exp=%h", lc, obs(), txn_exp(lc, w, nq, oq, oqv));
      end
      if (lc == 2) bus.req = '0;
    end
    model_done(w, nq);
    $display("[TB] txn hold_abort_restart: req=0110 winner=%0d q=%h", w, nq);
  endtask

  task automatic test_random();
    int         w;
    logic [3:0] r;
    logic [7:0] oq, nq;
    logic       oqv;
    for (int t = 0; t < 30; t++) begin
      r = 4'($urandom_range(0, 15));
      bus.req = r;
      bus.din = 32'($urandom);
      if (r == 4'b0) begin
        step();
        n_tests++;
        if (obs() !== idle_exp()) begin
          n_fail++; $display("FAIL random_idle t=%0d got=%h exp=%h", t, obs(), idle_exp());
        end
        $display("[TB] txn random %0d: req=0000 idle", t);
        continue;
      end
      w  = model_winner(r, m_ptr);
      oq = m_q; oqv = m_qv; nq = 8'h00;
      for (int lc = 1; lc <= 2 + H; lc++) begin
        step();
        n_tests++;
        if (obs() !== txn_exp(lc, w, nq, oq, oqv)) begin
          n_fail++; $display("FAIL random t=%0d lc=%0d got=%h exp=%h", t, lc, obs(), txn_exp(lc, w, nq, oq, oqv));
        end
        n_tests++;
        if ((bus.ack & ~bus.gnt) != 4'b0 || $countones(bus.gnt) > 1) begin
          n_fail++; $display("FAIL random_invariant t=%0d gnt=%b ack=%b", t, bus.gnt, bus.ack);
        end
        // Data presented during the grant cycle is what the load edge captures.
        if (lc == 1) begin
          bus.din = 32'($urandom);
          nq = bus.din[w*W +: W];
        end
        if (lc >= 2) begin
          bus.din = 32'($urandom);
          bus.req = 4'($urandom_range(0, 15));
        end
      end
      model_done(w, nq);
      $display("[TB] txn random %0d: req=%b winner=%0d q=%h", t, r, w, nq);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_drop_req();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
